// File: rtl/ledr_fx_driver.sv
// LEDR output stage: gates the software LED pattern with global PWM brightness
// and an optional blink, configured through a small zero-latency Avalon-MM slave.
`timescale 1ns/1ps
module ledr_fx_driver #(
  parameter int WIDTH        = 10,
  parameter int PWM_PRESCALE = 195
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] led_pattern,
  output logic [WIDTH-1:0] ledr
);

  localparam logic [15:0] PRE_LAST = 16'(PWM_PRESCALE - 1);

  logic             enable_reg;
  logic             blink_en_reg;
  logic [7:0]       bright_reg;
  logic [23:0]      blink_div_reg;
  logic [WIDTH-1:0] pattern_q_reg;
  logic [15:0]      pre_cnt_reg;
  logic [7:0]       pwm_cnt_reg;
  logic [23:0]      blink_cnt_reg;
  logic             blink_phase_reg;
  logic [WIDTH-1:0] ledr_reg;

  logic wr_en;
  logic tick;
  logic pwm_on;
  logic led_gate;
  logic unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign tick         = (pre_cnt_reg == PRE_LAST);
  assign pwm_on       = (bright_reg == 8'hFF) | (pwm_cnt_reg < bright_reg);
  assign led_gate     = enable_reg & pwm_on & (~blink_en_reg | blink_phase_reg);
  assign unused_wdata = ^writedata[31:24];
  assign ledr         = ledr_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_reg   <= 1'b1;
      blink_en_reg <= 1'b0;
      bright_reg   <= 8'hFF;
    end else if (wr_en) begin
      if (address == 2'd0) begin
        enable_reg   <= writedata[0];
        blink_en_reg <= writedata[1];
      end
      if (address == 2'd1) begin
        bright_reg <= writedata[7:0];
      end
    end
  end

  // Prescaler and PWM frame counter run freely; config writes never disturb them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_reg <= '0;
      pwm_cnt_reg <= '0;
    end else begin
      pre_cnt_reg <= tick ? 16'd0 : pre_cnt_reg + 16'd1;
      if (tick) begin
        pwm_cnt_reg <= pwm_cnt_reg + 8'd1;
      end
    end
  end

  // A BLINK_DIV write restarts the blink in the "on" phase and beats a coincident tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_div_reg   <= '0;
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b1;
    end else if (wr_en && address == 2'd2) begin
      blink_div_reg   <= writedata[23:0];
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b1;
    end else if (blink_div_reg == 24'd0) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b1;
    end else if (tick) begin
      if (blink_cnt_reg == blink_div_reg - 24'd1) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 24'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pattern_q_reg <= '0;
      ledr_reg      <= '0;
    end else begin
      pattern_q_reg <= led_pattern;
      ledr_reg      <= pattern_q_reg & {WIDTH{led_gate}};
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: readdata[1:0] = {blink_en_reg, enable_reg};
      2'd1: readdata[7:0] = bright_reg;
      2'd2: readdata[23:0] = blink_div_reg;
      default: begin
        readdata[0]         = blink_phase_reg;
        readdata[WIDTH+7:8] = pattern_q_reg;
      end
    endcase
  end

endmodule

// File: tb/tb_ledr_fx_driver.sv
// Randomized scoreboard bench for ledr_fx_driver against a closed-form timing model.
`timescale 1ns/1ps
module tb_ledr_fx_driver;

  localparam int W = 10;
  localparam int P = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [W-1:0]  led_pattern = '0;
  logic [W-1:0]  ledr;

  always #5 clk = ~clk;

  ledr_fx_driver #(.WIDTH(W), .PWM_PRESCALE(P)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .led_pattern(led_pattern), .ledr(ledr)
  );

  int n_checks = 0;
  int n_pass = 0;

  logic [W-1:0]  exp_q[$];
  logic [31:0]   rd_exp_q[$];
  logic [1:0]    rd_addr_q[$];
  logic          rd_req = 1'b0;

  // Model: m_k = edges since reset, m_n = ticks since the blink last restarted.
  int            m_k, m_n, m_div, m_pwm;
  logic          m_en, m_ben, m_tick, m_gate, m_wr;
  logic [7:0]    m_bright;
  logic [W-1:0]  m_pq;

  function automatic logic m_phase();
    if (m_div == 0) return 1'b1;
    return ((m_n / m_div) % 2) == 0;
  endfunction

  function automatic logic [31:0] m_read(logic [1:0] a);
    case (a)
      2'd0: return {30'd0, m_ben, m_en};
      2'd1: return {24'd0, m_bright};
      2'd2: return 32'(m_div);
      default: return ({22'd0, m_pq} << 8) | {31'd0, m_phase()};
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_k = 0; m_n = 0; m_div = 0; m_en = 1'b1; m_ben = 1'b0;
      m_bright = 8'hFF; m_pq = '0;
      exp_q.delete();
    end else begin
      m_tick = (m_k % P) == (P - 1);
      m_pwm  = (m_k / P) % 256;
      m_gate = m_en && (m_bright == 8'hFF || m_pwm < int'(m_bright)) && (!m_ben || m_phase());
      exp_q.push_back(m_gate ? m_pq : '0);
      m_pq = led_pattern;
      m_wr = chipselect && !write_n;
      if (m_wr && address == 2'd0) begin
        m_en = writedata[0]; m_ben = writedata[1];
      end
      if (m_wr && address == 2'd1) m_bright = writedata[7:0];
      if (m_wr && address == 2'd2) begin
        m_div = int'(writedata[23:0]); m_n = 0;
      end else if (m_div != 0 && m_tick) begin
        m_n++;
      end
      m_k++;
    end
  end

  // Monitor: one ledr comparison per cycle, plus any pending read.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [31:0]  re;
    logic [1:0]   ra;
    if (!reset_n) check("ledr_in_reset", 32'(ledr), 32'd0);
    else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ledr", 32'(ledr), 32'(e));
    end
    if (rd_req && rd_exp_q.size() > 0) begin
      re = rd_exp_q.pop_front();
      ra = rd_addr_q.pop_front();
      $display("read  addr=%0d data=0x%0h expected=0x%0h", ra, readdata, re);
      check($sformatf("read_addr%0d", ra), readdata, re);
    end
  end

  // All stimulus tasks start and end 2 ns after a rising edge.
  task automatic cyc(int n);
    repeat (n) begin
      @(posedge clk); #2;
    end
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
    $display("write addr=%0d data=0x%0h", a, d);
    @(posedge clk); #2;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(logic [1:0] a);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    rd_exp_q.push_back(m_read(a));
    rd_addr_q.push_back(a);
    rd_req = 1'b1;
    @(negedge clk); #1;
    rd_req = 1'b0; chipselect = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int on_cnt, guard;
    logic [31:0] d;
    logic [1:0]  a;

    // Reset release with a static pattern.
    led_pattern = 10'h2A5;
    repeat (3) @(posedge clk);
    #2; reset_n = 1'b1;
    cyc(4);
    check("reset_release_ledr", 32'(ledr), 32'h2A5);
    rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);

    // Brightness 0x40: 128 of every 512 cycles lit.
    led_pattern = 10'h3FF;
    wr(2'd1, 32'h40);
    cyc(4);
    on_cnt = 0;
    for (int i = 0; i < 512; i++) begin
      cyc(1);
      if (ledr == 10'h3FF) on_cnt++;
    end
    check("bright40_on_cycles", 32'(on_cnt), 32'd128);
    wr(2'd1, 32'h0);
    on_cnt = 0;
    for (int i = 0; i < 600; i++) begin
      cyc(1);
      if (ledr != '0) on_cnt++;
    end
    check("bright0_on_cycles", 32'(on_cnt), 32'd0);
    wr(2'd1, 32'hFF);

    // Blink with half-period 4 ticks.
    wr(2'd2, 32'd4);
    wr(2'd0, 32'h3);
    for (int i = 0; i < 12; i++) begin
      cyc(3);
      rd(2'd3);
    end

    // Restart during the off phase.
    for (guard = 0; guard < 200 && m_phase(); guard++) cyc(1);
    check("found_off_phase", 32'(guard < 200), 32'd1);
    wr(2'd2, 32'd4);
    rd(2'd3);
    cyc(20);

    // Restart write coinciding with a wrap tick.
    for (guard = 0; guard < 200; guard++) begin
      if ((m_k % P) == P - 1 && ((m_n + 1) % m_div) == 0) break;
      cyc(1);
    end
    check("found_wrap_tick", 32'(guard < 200), 32'd1);
    wr(2'd2, 32'd4);
    rd(2'd3);
    cyc(20);

    // Enable off while the pattern moves, then back on.
    wr(2'd0, 32'h0);
    for (int i = 0; i < 20; i++) begin
      led_pattern = W'($urandom);
      cyc(1);
    end
    wr(2'd0, 32'h1);
    for (int i = 0; i < 20; i++) begin
      led_pattern = W'($urandom);
      cyc(1);
    end
    rd(2'd0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      led_pattern = W'($urandom);
      a = 2'($urandom_range(0, 3));
      d = $urandom;
      if (a == 2'd2) d = d & 32'hFF00_0007;
      if (a == 2'd1 && $urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFF;
      case ($urandom_range(0, 9))
        0, 1: wr(a, d);
        2, 3: rd(a);
        default: cyc(1);
      endcase
    end

    // Asynchronous reset in the middle of a dim blink.
    led_pattern = 10'h3FF;
    wr(2'd1, 32'h10);
    wr(2'd2, 32'd3);
    wr(2'd0, 32'h3);
    for (guard = 0; guard < 2000 && ledr == '0; guard++) cyc(1);
    check("found_lit_before_reset", 32'(guard < 2000), 32'd1);
    #1 reset_n = 1'b0;
    #1 check("async_reset_ledr", 32'(ledr), 32'd0);
    cyc(3);
    reset_n = 1'b1;
    rd(2'd1); rd(2'd2); rd(2'd3); rd(2'd0);
    cyc(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
